// File: rtl/stream_fifo_if.sv
// stream_fifo_if: valid/ready write and read streams of a FIFO
interface stream_fifo_if #(parameter int WIDTH = 32);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
  modport slave  (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: single-clock FWFT FIFO with level, thresholds and sticky ovf/udf diagnostics
module stream_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          clr_err,
  stream_fifo_if.slave  s,
  output logic [LW-1:0] level,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          ovf,
  output logic          udf
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, wr_fire, rd_fire;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign full         = level == LW'(DEPTH);
  assign empty        = level == '0;
  assign wr_fire      = s.wr_valid && !full;
  assign rd_fire      = s.rd_ready && !empty;
  assign s.wr_ready   = !full;
  assign s.rd_valid   = !empty;
  assign s.rd_data    = mem[rd_ptr];
  assign almost_full  = level >= LW'(AF_LEVEL);
  assign almost_empty = level <= LW'(AE_LEVEL);
  always_ff @(posedge clk)
    if (wr_fire && !flush) mem[wr_ptr] <= s.wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_fire ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= rd_fire ? inc(rd_ptr) : rd_ptr;
      level  <= (wr_fire && !rd_fire) ? level + LW'(1) : (rd_fire && !wr_fire) ? level - LW'(1) : level;
    end
  // set beats clear so an event in the clearing cycle is never lost
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= (s.wr_valid && full) ? 1'b1 : clr_err ? 1'b0 : ovf;
      udf <= (s.rd_ready && empty) ? 1'b1 : clr_err ? 1'b0 : udf;
    end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed and randomized checks of stream_fifo against a queue model
module tb_stream_fifo;
  localparam int W = 8, D = 5, AF = 4, AE = 1, LW = $clog2(D + 1);
  logic clk = 0, rst = 1, flush = 0, clr_err = 0;
  logic [LW-1:0] level;
  logic almost_full, almost_empty, ovf, udf;
  int checks = 0, failures = 0;
  logic [W-1:0] q[$];
  logic m_ovf = 0, m_udf = 0;
  stream_fifo_if #(.WIDTH(W)) bus();
  stream_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .s(bus), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty), .ovf(ovf), .udf(udf));
  always #5 clk = ~clk;
  task automatic cycle(input logic wv, input logic [W-1:0] wd, input logic rr, input logic fl, input logic ce);
    bit w, r;
    int n;
    bus.wr_valid = wv; bus.wr_data = wd; bus.rd_ready = rr; flush = fl; clr_err = ce;
    n = q.size();
    w = wv && n < D;
    r = rr && n > 0;
    m_ovf = (wv && n == D) ? 1'b1 : ce ? 1'b0 : m_ovf;
    m_udf = (rr && n == 0) ? 1'b1 : ce ? 1'b0 : m_udf;
    if (fl) q.delete();
    else begin
      if (r) void'(q.pop_front());
      if (w) q.push_back(wd);
    end
    @(posedge clk); #1;
    bus.wr_valid = 0; bus.rd_ready = 0; flush = 0; clr_err = 0;
  endtask
  task automatic test_reset();
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h02, 0, 0, 0);
    #3 rst = 1;
    #1;
    q.delete(); m_ovf = 0; m_udf = 0;
    checks++; if (level !== 0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (bus.wr_ready !== 1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (almost_empty !== 1 || almost_full !== 0) begin failures++; $display("FAIL reset_almost got=%b%b exp=10", almost_empty, almost_full); end
    checks++; if (ovf !== 0 || udf !== 0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", ovf, udf); end
    @(posedge clk); #1 rst = 0;
    cycle(1, 8'h3c, 0, 0, 0);
    checks++; if (bus.rd_data !== 8'h3c || level !== 1) begin failures++; $display("FAIL reset_first_write got=%h/%0d exp=3c/1", bus.rd_data, level); end
    cycle(0, 0, 1, 0, 0);
  endtask
  task automatic test_fill_drain();
    for (int i = 0; i < D; i++) cycle(1, 8'h11 + 8'(i), 0, 0, 0);
    checks++; if (level !== 5) begin failures++; $display("FAIL fill_level got=%0d exp=5", level); end
    checks++; if (bus.wr_ready !== 0) begin failures++; $display("FAIL fill_wr_ready got=%b exp=0", bus.wr_ready); end
    checks++; if (almost_full !== 1 || ovf !== 0) begin failures++; $display("FAIL fill_af_ovf got=%b%b exp=10", almost_full, ovf); end
    cycle(1, 8'h16, 0, 0, 0);
    checks++; if (ovf !== 1 || level !== 5) begin failures++; $display("FAIL fill_ovf got=%b/%0d exp=1/5", ovf, level); end
    for (int i = 0; i < D; i++) begin
      checks++; if (bus.rd_valid !== 1 || bus.rd_data !== 8'h11 + 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, bus.rd_valid, bus.rd_data, 8'h11 + 8'(i)); end
      checks++; if (almost_empty !== (D - i <= AE)) begin failures++; $display("FAIL drain_ae[%0d] got=%b exp=%b", i, almost_empty, D - i <= AE); end
      cycle(0, 0, 1, 0, 0);
    end
    checks++; if (bus.rd_valid !== 0 || level !== 0 || udf !== 0) begin failures++; $display("FAIL drain_empty got=%b/%0d/%b exp=0/0/0", bus.rd_valid, level, udf); end
    cycle(0, 0, 1, 0, 0);
    checks++; if (udf !== 1) begin failures++; $display("FAIL drain_udf got=%b exp=1", udf); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (ovf !== 0 || udf !== 0) begin failures++; $display("FAIL clr_err got=%b%b exp=00", ovf, udf); end
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 3; i++) cycle(1, 8'h20 + 8'(i), 0, 0, 0);
    for (int k = 0; k < 13; k++) begin
      checks++; if (bus.rd_data !== 8'h20 + 8'(k) || level !== 3) begin failures++; $display("FAIL wrap[%0d] got=%h/%0d exp=%h/3", k, bus.rd_data, level, 8'h20 + 8'(k)); end
      cycle(1, 8'h23 + 8'(k), 1, 0, 0);
    end
    for (int j = 0; j < 3; j++) begin
      checks++; if (bus.rd_data !== 8'h2d + 8'(j)) begin failures++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", j, bus.rd_data, 8'h2d + 8'(j)); end
      cycle(0, 0, 1, 0, 0);
    end
    checks++; if (level !== 0) begin failures++; $display("FAIL wrap_level got=%0d exp=0", level); end
  endtask
  task automatic test_concurrency();
    for (int i = 0; i < D; i++) cycle(1, 8'h31 + 8'(i), 0, 0, 0);
    cycle(1, 8'h99, 1, 0, 0);
    checks++; if (level !== 4 || bus.rd_data !== 8'h32) begin failures++; $display("FAIL full_both got=%0d/%h exp=4/32", level, bus.rd_data); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rd_data !== 8'h32 + 8'(i)) begin failures++; $display("FAIL full_both_drain[%0d] got=%h exp=%h", i, bus.rd_data, 8'h32 + 8'(i)); end
      cycle(0, 0, 1, 0, 0);
    end
    checks++; if (bus.rd_valid !== 0) begin failures++; $display("FAIL empty_both_rv got=%b exp=0", bus.rd_valid); end
    cycle(1, 8'h77, 1, 0, 0);
    checks++; if (level !== 1 || bus.rd_data !== 8'h77 || udf !== 1) begin failures++; $display("FAIL empty_both got=%0d/%h/%b exp=1/77/1", level, bus.rd_data, udf); end
    cycle(0, 0, 1, 0, 1);
  endtask
  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1, 8'h41 + 8'(i), 0, 0, 0);
    cycle(1, 8'h55, 1, 1, 0);
    checks++; if (level !== 0 || bus.rd_valid !== 0) begin failures++; $display("FAIL flush_level got=%0d/%b exp=0/0", level, bus.rd_valid); end
    cycle(1, 8'ha5, 0, 0, 0);
    checks++; if (bus.rd_data !== 8'ha5 || level !== 1) begin failures++; $display("FAIL flush_next got=%h/%0d exp=a5/1", bus.rd_data, level); end
    for (int i = 0; i < D; i++) cycle(1, 8'h60, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    checks++; if (ovf !== 1 || level !== 0) begin failures++; $display("FAIL flush_keeps_ovf got=%b/%0d exp=1/0", ovf, level); end
    cycle(0, 0, 0, 0, 1);
  endtask
  task automatic test_random();
    int wp;
    logic wv, rr, fl, ce;
    for (int i = 0; i < 10000; i++) begin
      wp = ((i / 150) % 2) ? 75 : 30;
      wv = $urandom_range(0, 99) < wp;
      rr = $urandom_range(0, 99) < 100 - wp;
      fl = $urandom_range(0, 299) == 0;
      ce = $urandom_range(0, 99) == 0;
      checks++; if (bus.rd_valid !== (q.size() > 0) || (q.size() > 0 && bus.rd_data !== q[0])) begin failures++; $display("FAIL rand_head[%0d] got=%b/%h exp=%b/%h", i, bus.rd_valid, bus.rd_data, q.size() > 0, q.size() > 0 ? q[0] : 8'h0); end
      cycle(wv, W'($urandom), rr, fl, ce);
      checks++; if (level !== LW'(q.size()) || level > D) begin failures++; $display("FAIL rand_level[%0d] got=%0d exp=%0d", i, level, q.size()); end
      checks++; if (bus.wr_ready !== (q.size() < D) || almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE)) begin failures++; $display("FAIL rand_flags[%0d] got=%b%b%b size=%0d", i, bus.wr_ready, almost_full, almost_empty, q.size()); end
      checks++; if (ovf !== m_ovf || udf !== m_udf) begin failures++; $display("FAIL rand_err[%0d] got=%b%b exp=%b%b", i, ovf, udf, m_ovf, m_udf); end
    end
  endtask
  initial begin
    bus.wr_valid = 0; bus.wr_data = 0; bus.rd_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_concurrency();
    test_flush();
    test_random();
    checks++; if (ovf !== m_ovf || udf !== m_udf) begin failures++; $display("FAIL end_err got=%b%b exp=%b%b", ovf, udf, m_ovf, m_udf); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
